// File: rtl/rv32_pkg.sv
// Shared types for the RV32 pipeline hazard controller: FSM states, the
// stall/flush bundle and the hard-wired zero register index.
package rv32_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } pipe_ctrl_state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
    logic flush_mem_wb;
  } pipe_ctrl_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  // A source operand conflicts only if it is really read and names the producer.
  function automatic logic src_hit(input logic v, input logic [4:0] rs, input logic [4:0] rd);
    return v && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_ctrl_mdu_seq.sv
// MDU occupancy sequencer: issues the operand-latch pulse and holds the front
// of the pipe while a multi-cycle MUL/DIV/REM sits in EX.
module pipe_ctrl_mdu_seq
  import rv32_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic ex_mdu_op,
  input  logic mem_busy,
  output logic mdu_hold,
  output logic mdu_start
);

  localparam int CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LAT - 1);

  pipe_ctrl_state_e r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter keeps running under mem_busy; a finish during a dmem wait parks in MDU_DONE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (ex_mdu_op && !mem_busy) begin
          w_state_nxt = MDU_BUSY;
          w_cnt_nxt   = CNT_INIT;
        end
      end
      MDU_BUSY: begin
        if (w_cnt_zero) w_state_nxt = mem_busy ? MDU_DONE : RUN;
        else            w_cnt_nxt   = r_cnt - 1'b1;
      end
      MDU_DONE: begin
        if (!mem_busy) w_state_nxt = RUN;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    mdu_start = 1'b0;
    mdu_hold  = 1'b0;
    case (r_state)
      RUN: begin
        mdu_start = ex_mdu_op && !mem_busy;
        mdu_hold  = ex_mdu_op && !mem_busy;
      end
      MDU_BUSY: mdu_hold = !w_cnt_zero || mem_busy;
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipe. Priority is
// mem_busy > MDU > redirect > load-use. PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl
  import rv32_pkg::*;
#(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_v,
  input  logic             id_rs2_v,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_mdu_op,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             stall_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             flush_mem_wb,
  output logic             redirect_take,
  output logic             mdu_start,
  output logic [CNT_W-1:0] perf_ldu,
  output logic [CNT_W-1:0] perf_mdu,
  output logic [CNT_W-1:0] perf_mem,
  output logic [CNT_W-1:0] perf_redir
);

  pipe_ctrl_t w_ctl;
  logic       w_mdu_hold, w_mdu_start;
  logic       w_ldu, w_ldu_fire, w_mdu_fire, w_take;

  pipe_ctrl_mdu_seq #(.MDU_LAT(MDU_LAT)) u_mdu_seq (
    .clk       (clk),
    .resetn    (resetn),
    .ex_mdu_op (ex_mdu_op),
    .mem_busy  (mem_busy),
    .mdu_hold  (w_mdu_hold),
    .mdu_start (w_mdu_start)
  );

  assign w_ldu = ex_is_load && (ex_rd != REG_X0) &&
                 (src_hit(id_rs1_v, id_rs1, ex_rd) || src_hit(id_rs2_v, id_rs2, ex_rd));

  // A taken redirect squashes the ID instruction, so it also wins over load-use.
  always_comb begin
    w_ctl      = '0;
    w_take     = 1'b0;
    w_ldu_fire = 1'b0;
    w_mdu_fire = 1'b0;
    if (mem_busy) begin
      w_ctl.stall_pc     = 1'b1;
      w_ctl.stall_if_id  = 1'b1;
      w_ctl.stall_id_ex  = 1'b1;
      w_ctl.stall_ex_mem = 1'b1;
      w_ctl.flush_mem_wb = 1'b1;
    end else if (w_mdu_hold) begin
      w_ctl.stall_pc     = 1'b1;
      w_ctl.stall_if_id  = 1'b1;
      w_ctl.stall_id_ex  = 1'b1;
      w_ctl.flush_ex_mem = 1'b1;
      w_mdu_fire         = 1'b1;
    end else if (ex_redirect) begin
      w_take             = 1'b1;
      w_ctl.flush_if_id  = 1'b1;
      w_ctl.flush_id_ex  = 1'b1;
    end else if (w_ldu) begin
      w_ctl.stall_pc     = 1'b1;
      w_ctl.stall_if_id  = 1'b1;
      w_ctl.flush_id_ex  = 1'b1;
      w_ldu_fire         = 1'b1;
    end
  end

  assign stall_pc      = resetn & w_ctl.stall_pc;
  assign stall_if_id   = resetn & w_ctl.stall_if_id;
  assign stall_id_ex   = resetn & w_ctl.stall_id_ex;
  assign stall_ex_mem  = resetn & w_ctl.stall_ex_mem;
  assign flush_if_id   = resetn & w_ctl.flush_if_id;
  assign flush_id_ex   = resetn & w_ctl.flush_id_ex;
  assign flush_ex_mem  = resetn & w_ctl.flush_ex_mem;
  assign flush_mem_wb  = resetn & w_ctl.flush_mem_wb;
  assign redirect_take = resetn & w_take;
  assign mdu_start     = resetn & w_mdu_start;

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_perf_ldu, r_perf_mdu, r_perf_mem, r_perf_redir;

  // Saturate rather than wrap so long runs never report a misleadingly small count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_ldu   <= '0;
      r_perf_mdu   <= '0;
      r_perf_mem   <= '0;
      r_perf_redir <= '0;
    end else begin
      if (w_ldu_fire && (r_perf_ldu   != '1)) r_perf_ldu   <= r_perf_ldu   + 1'b1;
      if (w_mdu_fire && (r_perf_mdu   != '1)) r_perf_mdu   <= r_perf_mdu   + 1'b1;
      if (mem_busy   && (r_perf_mem   != '1)) r_perf_mem   <= r_perf_mem   + 1'b1;
      if (w_take     && (r_perf_redir != '1)) r_perf_redir <= r_perf_redir + 1'b1;
    end
  end

  assign perf_ldu   = r_perf_ldu;
  assign perf_mdu   = r_perf_mdu;
  assign perf_mem   = r_perf_mem;
  assign perf_redir = r_perf_redir;
`else
  logic w_unused;
  assign w_unused   = w_ldu_fire ^ w_mdu_fire;
  assign perf_ldu   = '0;
  assign perf_mdu   = '0;
  assign perf_mem   = '0;
  assign perf_redir = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table for single-cycle hazards plus
// hand sequences for MDU occupancy, dmem waits, redirect hold-off and reset.
module tb_pipe_ctrl;
  import rv32_pkg::*;

  localparam int MDU_LAT = 4;
  localparam int CNT_W   = 32;

  logic clk = 1'b0;
  logic resetn;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_v, id_rs2_v, ex_is_load, ex_mdu_op, ex_redirect, mem_busy;
  logic stall_pc, stall_if_id, stall_id_ex, stall_ex_mem;
  logic flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb;
  logic redirect_take, mdu_start;
  logic [CNT_W-1:0] perf_ldu, perf_mdu, perf_mem, perf_redir;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.MDU_LAT(MDU_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_v(id_rs1_v), .id_rs2_v(id_rs2_v),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_mdu_op(ex_mdu_op),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .stall_id_ex(stall_id_ex),
    .stall_ex_mem(stall_ex_mem), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem), .flush_mem_wb(flush_mem_wb),
    .redirect_take(redirect_take), .mdu_start(mdu_start),
    .perf_ldu(perf_ldu), .perf_mdu(perf_mdu), .perf_mem(perf_mem), .perf_redir(perf_redir)
  );

  pipe_ctrl_t act;
  assign act = {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
                flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb};

  // {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb}
  localparam pipe_ctrl_t C_NONE = 8'b0000_0000;
  localparam pipe_ctrl_t C_LDU  = 8'b1100_0100;
  localparam pipe_ctrl_t C_REDR = 8'b0000_1100;
  localparam pipe_ctrl_t C_MEM  = 8'b1111_0001;
  localparam pipe_ctrl_t C_MDU  = 8'b1110_0010;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2;
    logic       v1, v2;
    logic [4:0] rd;
    logic       ld, md, rdr, mb;
    pipe_ctrl_t e_ctl;
    logic       e_take, e_start;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input pipe_ctrl_t ec, input logic et, input logic es);
    n_chk++;
    if ({act, redirect_take, mdu_start} !== {ec, et, es}) begin
      n_fail++;
      $display("FAIL %s: got ctl=%b take=%b start=%b, want ctl=%b take=%b start=%b",
               nm, act, redirect_take, mdu_start, ec, et, es);
    end
  endtask

  task automatic chk_perf_zero(input string nm);
    n_chk++;
    if ({perf_ldu, perf_mdu, perf_mem, perf_redir} !== '0) begin
      n_fail++;
      $display("FAIL %s: got perf ldu=%0d mdu=%0d mem=%0d redir=%0d, want all 0",
               nm, perf_ldu, perf_mdu, perf_mem, perf_redir);
    end
  endtask

  // Inputs change at negedge; outputs are sampled 1ns later, well clear of posedge.
  task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic v1, input logic v2,
                       input logic [4:0] rd, input logic ld, input logic md, input logic rdr,
                       input logic mb);
    @(negedge clk);
    id_rs1 = rs1; id_rs2 = rs2; id_rs1_v = v1; id_rs2_v = v2;
    ex_rd = rd; ex_is_load = ld; ex_mdu_op = md; ex_redirect = rdr; mem_busy = mb;
    #1;
  endtask

  task automatic ctl_in(input logic md, input logic rdr, input logic mb);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, md, rdr, mb);
  endtask

  initial begin
    vecs.push_back('{"idle",          5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 0, 0});
    vecs.push_back('{"ldu_rs1",       5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 0, 0, C_LDU,  0, 0});
    vecs.push_back('{"ldu_x0",        5'd0, 5'd1, 1, 1, 5'd0, 1, 0, 0, 0, C_NONE, 0, 0});
    vecs.push_back('{"ldu_rs2",       5'd2, 5'd7, 1, 1, 5'd7, 1, 0, 0, 0, C_LDU,  0, 0});
    vecs.push_back('{"ldu_rs2_unread",5'd2, 5'd7, 1, 0, 5'd7, 1, 0, 0, 0, C_NONE, 0, 0});
    vecs.push_back('{"no_load",       5'd5, 5'd1, 1, 1, 5'd5, 0, 0, 0, 0, C_NONE, 0, 0});
    vecs.push_back('{"ldu_redirect",  5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 1, 0, C_REDR, 1, 0});
    vecs.push_back('{"mem_busy",      5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, C_MEM,  0, 0});
    vecs.push_back('{"mem_over_all",  5'd5, 5'd1, 1, 1, 5'd5, 1, 0, 1, 1, C_MEM,  0, 0});
    vecs.push_back('{"mdu_memwait",   5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, C_MEM,  0, 0});
    vecs.push_back('{"after_mdu_wait",5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, C_NONE, 0, 0});

    resetn = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_rs1_v = 0; id_rs2_v = 0; ex_rd = '0;
    ex_is_load = 0; ex_mdu_op = 0; ex_redirect = 0; mem_busy = 0;
    #12;
    // Outputs must stay quiet under reset even with hazards asserted.
    ex_is_load = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_v = 1; mem_busy = 1; ex_mdu_op = 1;
    #1;
    chk("reset_outputs", C_NONE, 1'b0, 1'b0);
    chk_perf_zero("reset_perf");
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i])
      begin
        drive(vecs[i].rs1, vecs[i].rs2, vecs[i].v1, vecs[i].v2, vecs[i].rd,
              vecs[i].ld, vecs[i].md, vecs[i].rdr, vecs[i].mb);
        chk(vecs[i].name, vecs[i].e_ctl, vecs[i].e_take, vecs[i].e_start);
      end

    // Div in EX: entry + 3 held cycles, released on the cnt==0 cycle, then a fresh div issues.
    for (int c = 0; c < 6; c++) begin
      ctl_in(1'b1, 1'b0, 1'b0);
      case (c)
        0, 5:    chk($sformatf("mdu_c%0d", c), C_MDU,  1'b0, 1'b1);
        4:       chk($sformatf("mdu_c%0d", c), C_NONE, 1'b0, 1'b0);
        default: chk($sformatf("mdu_c%0d", c), C_MDU,  1'b0, 1'b0);
      endcase
    end
    for (int c = 0; c < 4; c++) ctl_in(1'b1, 1'b0, 1'b0);
    ctl_in(1'b0, 1'b0, 1'b0);
    chk("mdu2_done_idle", C_NONE, 1'b0, 1'b0);

    // mem_busy for 3 cycles overlapping cnt==0: parks in DONE, no re-issue on release.
    ctl_in(1'b1, 1'b0, 1'b0); chk("md_entry", C_MDU, 1'b0, 1'b1);
    ctl_in(1'b1, 1'b0, 1'b0); chk("md_cnt3",  C_MDU, 1'b0, 1'b0);
    ctl_in(1'b1, 1'b0, 1'b0); chk("md_cnt2",  C_MDU, 1'b0, 1'b0);
    ctl_in(1'b1, 1'b0, 1'b1); chk("md_mb1",   C_MEM, 1'b0, 1'b0);
    ctl_in(1'b1, 1'b0, 1'b1); chk("md_mb2",   C_MEM, 1'b0, 1'b0);
    ctl_in(1'b1, 1'b0, 1'b1); chk("md_mb3",   C_MEM, 1'b0, 1'b0);
    ctl_in(1'b1, 1'b0, 1'b0); chk("md_done_release", C_NONE, 1'b0, 1'b0);
    ctl_in(1'b0, 1'b0, 1'b0); chk("md_after", C_NONE, 1'b0, 1'b0);

    // Redirect held off by a 2-cycle dmem wait, then consumed once.
    ctl_in(1'b0, 1'b1, 1'b1); chk("redir_mb1",  C_MEM,  1'b0, 1'b0);
    ctl_in(1'b0, 1'b1, 1'b1); chk("redir_mb2",  C_MEM,  1'b0, 1'b0);
    ctl_in(1'b0, 1'b1, 1'b0); chk("redir_take", C_REDR, 1'b1, 1'b0);
    ctl_in(1'b0, 1'b0, 1'b0); chk("redir_idle", C_NONE, 1'b0, 1'b0);

    // Redirect while MDU holds EX is not taken.
    ctl_in(1'b1, 1'b1, 1'b0); chk("redir_mdu_entry", C_MDU, 1'b0, 1'b1);
    ctl_in(1'b1, 1'b1, 1'b0); chk("redir_mdu_busy",  C_MDU, 1'b0, 1'b0);

    // Reset mid MDU_BUSY aborts the sequence.
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("rst_mid_outputs", C_NONE, 1'b0, 1'b0);
    chk_perf_zero("rst_mid_perf");
    @(negedge clk);
    resetn = 1'b1;
    ex_mdu_op = 1'b0; ex_redirect = 1'b0;
    #1;
    chk("rst_back_run", C_NONE, 1'b0, 1'b0);
    ctl_in(1'b0, 1'b0, 1'b0); chk("rst_idle", C_NONE, 1'b0, 1'b0);
    ctl_in(1'b1, 1'b0, 1'b0); chk("rst_new_op", C_MDU, 1'b0, 1'b1);

`ifndef PIPE_CTRL_PERF_EN
    chk_perf_zero("perf_tied_off");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
